bcd_mul_seq: RTL

- Iterative packed-BCD multiplier controller.
- Multiplies two DIGITS-digit unsigned packed-BCD operands by sequencing one multiplier digit per cycle through a digit-by-N-digit partial-product datapath and a BCD accumulate stage.
- Sits beside the ALU as a multi-cycle functional unit: start/busy/done handshake, fixed latency.

---
 rtl/bcd_mul_seq.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/bcd_mul_seq.sv
// Sequential packed-BCD multiplier: one multiplier digit per cycle, MSB first,
// accumulating digit-by-N partial products into a 2*DIGITS-digit BCD product.
module bcd_mul_seq #(
   parameter int DIGITS = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  start_i,
   input  logic [4*DIGITS-1:0]   a_i,
   input  logic [4*DIGITS-1:0]   b_i,
   output logic                  ready_o,
   output logic                  busy_o,
   output logic                  done_o,
   output logic [8*DIGITS-1:0]   p_o,
   output logic                  err_o
);

   localparam int AW = 4 * DIGITS;
   localparam int PW = 8 * DIGITS;
   localparam int CW = $clog2(DIGITS);

   typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

   state_t          state, stateNext;
   logic [AW-1:0]   aReg, bReg;
   logic [PW-1:0]   acc;
   logic [CW-1:0]   count;
   logic            accept, badOp, lastDigit;
   logic [3:0]      dig;
   logic [PW-1:0]   unitsVec, tensVec;
   logic [PW:0]     ppFull, accFull;
   logic            accCarry;

   // Decimal add of two 2*DIGITS-digit values; returns {carryOut, sum}.
   function automatic logic [PW:0] bcdAdd(input logic [PW-1:0] x, input logic [PW-1:0] y);
      logic [PW-1:0] s;
      logic          c;
      logic [4:0]    t;
      s = '0;
      c = 1'b0;
      for (int i = 0; i < 2 * DIGITS; i++) begin
         t = {1'b0, x[4*i +: 4]} + {1'b0, y[4*i +: 4]} + {4'd0, c};
         if (t > 5'd9) begin
            t = t + 5'd6;
            c = 1'b1;
         end else begin
            c = 1'b0;
         end
         s[4*i +: 4] = t[3:0];
      end
      return {c, s};
   endfunction

   // Single-digit product split into {tens, units}.
   function automatic logic [7:0] digitMul(input logic [3:0] x, input logic [3:0] y);
      logic [6:0] prod, tens, units;
      prod  = {3'd0, x} * {3'd0, y};
      tens  = prod / 7'd10;
      units = prod - tens * 7'd10;
      return {tens[3:0], units[3:0]};
   endfunction

   function automatic logic nonBcd(input logic [AW-1:0] v);
      logic bad;
      bad = 1'b0;
      for (int i = 0; i < DIGITS; i++)
         if (v[4*i +: 4] > 4'd9) bad = 1'b1;
      return bad;
   endfunction

   assign dig       = bReg[AW-1 -: 4];
   assign lastDigit = (count == CW'(DIGITS - 1));
   assign badOp     = nonBcd(a_i) | nonBcd(b_i);

   always_comb begin
      unitsVec = '0;
      tensVec  = '0;
      for (int i = 0; i < DIGITS; i++) begin
         logic [7:0] m;
         m = digitMul(aReg[4*i +: 4], dig);
         unitsVec[4*i +: 4]     = m[3:0];
         tensVec[4*(i+1) +: 4]  = m[7:4];
      end
   end

   assign ppFull   = bcdAdd(unitsVec, tensVec);
   assign accFull  = bcdAdd(acc << 4, ppFull[PW-1:0]);
   // Either carry being set means the product escaped 2*DIGITS digits.
   assign accCarry = accFull[PW] | ppFull[PW];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state <= IDLE;
      else         state <= stateNext;
   end

   always_comb begin
      stateNext = state;
      accept    = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (start_i) begin
               accept    = 1'b1;
               stateNext = badOp ? DONE : MUL;
            end else if (state == DONE) begin
               stateNext = IDLE;
            end
         end
         MUL:     if (lastDigit) stateNext = DONE;
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         acc   <= '0;
         count <= '0;
         p_o   <= '0;
         err_o <= 1'b0;
      end else if (accept) begin
         acc   <= '0;
         count <= '0;
         err_o <= badOp;
         if (badOp) p_o <= '0;
      end else if (state == MUL) begin
         acc   <= accFull[PW-1:0];
         count <= count + 1'b1;
         if (lastDigit) p_o <= accFull[PW-1:0];
      end
   end

   // Operand registers carry no reset; they are always loaded before use.
   always_ff @(posedge clk_i) begin
      if (accept) begin
         aReg <= a_i;
         bReg <= b_i;
      end else if (state == MUL) begin
         bReg <= bReg << 4;
      end
   end

   assign busy_o  = (state == MUL);
   assign done_o  = (state == DONE);
   assign ready_o = ~busy_o;

endmodule
